hash_ram_p: RTL and testbench

HASH_RAM_P -- requirements
Module: hash_ram_p

---
 rtl/hash_ram_p.sv | 175 +++++++++++++++++
 tb/tb_hash_ram_p.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/hash_ram_p.sv
// ---------------------------------------------------------------------------
// hash_ram_p : open-addressed hash table held in registers.
//
// An inserted word is its own key. The home slot is the sum of the upper and
// lower halves of the word, modulo DEPTH. The probe then walks forward one
// slot per cycle, wrapping at the top, and stores the word in the first free
// slot it finds. Reads take one cycle and are accepted on every cycle.
//
// Optional feature (macro HASH_RAM_P_DEL_EN):
//   defined   -> del_en/del_addr free a slot while the table is idle
//   undefined -> del_en/del_addr are ignored; slots are freed only by reset
//
// Parameters:
//   DATA_W : word width (even, >= 4)
//   ADDR_W : slot address width, DEPTH = 2**ADDR_W
//
// Ports:
//   clk       in   clock, rising edge
//   reset_n   in   asynchronous active-low reset
//   wr_en     in   insert request (taken only when busy=0)
//   wr_data   in   word to insert / hash key
//   rd_en     in   read request (taken every cycle)
//   rd_addr   in   slot to read
//   del_en    in   delete request (taken only when busy=0)
//   del_addr  in   slot to free
//   rd_data   out  read data, 0 for an empty slot
//   rd_valid  out  read result present and slot occupied
//   wr_done   out  one-cycle insert-finished pulse
//   wr_slot   out  slot written, valid with wr_done
//   wr_err    out  table was full, nothing written, valid with wr_done
//   busy      out  insert in progress
//   full      out  every slot occupied
//   count     out  number of occupied slots
// ---------------------------------------------------------------------------
module hash_ram_p #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              del_en,
  input  logic [ADDR_W-1:0] del_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              wr_done,
  output logic [ADDR_W-1:0] wr_slot,
  output logic              wr_err,
  output logic              busy,
  output logic              full,
  output logic [ADDR_W:0]   count
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam int SUM_W = ADDR_W + DATA_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PROBE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t              r_state;
  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic [DEPTH-1:0]    r_occ;
  logic [DATA_W-1:0]   r_key;
  logic [ADDR_W-1:0]   r_probe;

  logic [SUM_W-1:0]    w_home_sum;
  logic [ADDR_W-1:0]   w_home;
  logic                w_del_hit;
  logic [ADDR_W:0]     w_count_inc;

  // Zero-extend both halves so the sum never truncates before the modulo.
  assign w_home_sum = {{(ADDR_W + DATA_W/2){1'b0}}, wr_data[DATA_W-1:DATA_W/2]}
                    + {{(ADDR_W + DATA_W/2){1'b0}}, wr_data[DATA_W/2-1:0]};
  assign w_home     = w_home_sum[ADDR_W-1:0];
  assign w_count_inc = count + (ADDR_W+1)'(1);

`ifdef HASH_RAM_P_DEL_EN
  // Only an occupied slot is freed, so count cannot underflow.
  assign w_del_hit = (r_state == IDLE) && del_en && r_occ[del_addr];
`else
  logic w_unused_del;
  assign w_unused_del = ^{del_en, del_addr};
  assign w_del_hit    = 1'b0;
`endif

  // Table state, read port and insert FSM.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_occ    <= '0;
      r_key    <= '0;
      r_probe  <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      wr_done  <= 1'b0;
      wr_slot  <= '0;
      wr_err   <= 1'b0;
      busy     <= 1'b0;
      full     <= 1'b0;
      count    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      // Read sees contents from before any write/delete on this same edge.
      if (rd_en && r_occ[rd_addr]) begin
        rd_data  <= r_mem[rd_addr];
        rd_valid <= 1'b1;
      end else begin
        rd_data  <= '0;
        rd_valid <= 1'b0;
      end

      wr_done <= 1'b0;
      wr_err  <= 1'b0;

      case (r_state)
        IDLE: begin
          if (w_del_hit) begin
            r_occ[del_addr] <= 1'b0;
            r_mem[del_addr] <= '0;
            count           <= count - (ADDR_W+1)'(1);
            full            <= 1'b0;
          end
          if (wr_en) begin
            busy <= 1'b1;
            // A same-cycle delete frees a slot, so the insert may proceed.
            if (full && !w_del_hit) begin
              r_state <= DONE;
              wr_done <= 1'b1;
              wr_err  <= 1'b1;
            end else begin
              r_key   <= wr_data;
              r_probe <= w_home;
              r_state <= PROBE;
            end
          end else begin
            busy <= 1'b0;
          end
        end
        PROBE: begin
          // A free slot is guaranteed: table was not full at accept and
          // deletes are blocked while busy.
          if (!r_occ[r_probe]) begin
            r_mem[r_probe] <= r_key;
            r_occ[r_probe] <= 1'b1;
            count          <= w_count_inc;
            full           <= (w_count_inc == DEPTH_C);
            wr_slot        <= r_probe;
            wr_done        <= 1'b1;
            r_state        <= DONE;
          end else begin
            r_probe <= r_probe + ADDR_W'(1);
          end
        end
        DONE: begin
          r_state <= IDLE;
          busy    <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hash_ram_p.sv
// ---------------------------------------------------------------------------
// tb_hash_ram_p : directed self-checking bench for hash_ram_p (defaults
// DATA_W=8, ADDR_W=5). Expected values are hand-computed from the hash rule
// (upper nibble + lower nibble) mod 32 and linear probing.
// ---------------------------------------------------------------------------
module tb_hash_ram_p;

  logic       clk;
  logic       reset_n;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       rd_en;
  logic [4:0] rd_addr;
  logic       del_en;
  logic [4:0] del_addr;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       wr_done;
  logic [4:0] wr_slot;
  logic       wr_err;
  logic       busy;
  logic       full;
  logic [5:0] count;

  int checks = 0;
  int errors = 0;

  hash_ram_p #(.DATA_W(8), .ADDR_W(5)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .del_en   (del_en),
    .del_addr (del_addr),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .wr_done  (wr_done),
    .wr_slot  (wr_slot),
    .wr_err   (wr_err),
    .busy     (busy),
    .full     (full),
    .count    (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Insert one word (optionally with a same-cycle delete); returns the number
  // of cycles from the accepting edge to the cycle wr_done is seen.
  task automatic insert(input logic [7:0] data, input logic del, input logic [4:0] daddr,
                        output int lat, output int slot, output int err);
    @(negedge clk);
    wr_data  = data;
    wr_en    = 1'b1;
    del_en   = del;
    del_addr = daddr;
    @(posedge clk);
    #1;
    wr_en  = 1'b0;
    del_en = 1'b0;
    lat  = 0;
    slot = -1;
    err  = -1;
    while (lat < 60) begin
      @(negedge clk);
      lat++;
      if (wr_done) begin
        slot = int'(wr_slot);
        err  = int'(wr_err);
        break;
      end
    end
    if (slot < 0) check("insert_timeout", 32'd0, 32'd1);
  endtask

  task automatic read_slot(input logic [4:0] a, output int data, output int valid);
    @(negedge clk);
    rd_en   = 1'b1;
    rd_addr = a;
    @(posedge clk);
    #1;
    rd_en = 1'b0;
    @(negedge clk);
    data  = int'(rd_data);
    valid = int'(rd_valid);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    int lat, slot, err, d, v;
    reset_n  = 1'b0;
    wr_en    = 1'b0;
    wr_data  = 8'h00;
    rd_en    = 1'b0;
    rd_addr  = 5'd0;
    del_en   = 1'b0;
    del_addr = 5'd0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_count", count, 0);
    check("rst_full", full, 0);
    check("rst_done", wr_done, 0);
    check("rst_rvalid", rd_valid, 0);

    // 0x12 -> home 3, empty table
    insert(8'h12, 1'b0, 5'd0, lat, slot, err);
    check("w12_lat", lat, 2);
    check("w12_slot", slot, 3);
    check("w12_err", err, 0);
    check("w12_count", count, 1);

    // 0x21 -> home 3 occupied, lands in 4
    insert(8'h21, 1'b0, 5'd0, lat, slot, err);
    check("w21_lat", lat, 3);
    check("w21_slot", slot, 4);
    check("w21_count", count, 2);
    read_slot(5'd4, d, v);
    check("rd4_data", d, 32'h21);
    check("rd4_valid", v, 1);
    read_slot(5'd3, d, v);
    check("rd3_data", d, 32'h12);

    // 0xFF -> home 30, wraps 30, 31, 0
    insert(8'hFF, 1'b0, 5'd0, lat, slot, err);
    check("wff1_slot", slot, 30);
    insert(8'hFF, 1'b0, 5'd0, lat, slot, err);
    check("wff2_slot", slot, 31);
    check("wff2_lat", lat, 3);
    insert(8'hFF, 1'b0, 5'd0, lat, slot, err);
    check("wff3_slot", slot, 0);
    check("wff3_lat", lat, 4);
    read_slot(5'd5, d, v);
    check("rd5_data", d, 0);
    check("rd5_valid", v, 0);
    check("count5", count, 5);

    // Fill remaining 27 slots, then one more must fail
    for (int i = 0; i < 27; i++) begin
      insert(8'h00, 1'b0, 5'd0, lat, slot, err);
      if (err != 0) check("fill_err", err, 0);
    end
    check("full_count", count, 32);
    check("full_flag", full, 1);
    insert(8'h55, 1'b0, 5'd0, lat, slot, err);
    check("ovf_lat", lat, 1);
    check("ovf_err", err, 1);
    check("ovf_count", count, 32);
    read_slot(5'd5, d, v);
    check("rd5_filled_valid", v, 1);

    // Reset in the middle of a probe
    do_reset();
    insert(8'hFF, 1'b0, 5'd0, lat, slot, err);
    check("mid_first_slot", slot, 30);
    @(negedge clk);
    wr_data = 8'hFF;
    wr_en   = 1'b1;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    check("mid_busy_probe", busy, 1);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("mid_busy", busy, 0);
    check("mid_count", count, 0);
    check("mid_done", wr_done, 0);
    check("mid_full", full, 0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("mid_no_done", wr_done, 0);
    end
    read_slot(5'd30, d, v);
    check("mid_rd30_valid", v, 0);
    read_slot(5'd31, d, v);
    check("mid_rd31_valid", v, 0);
    check("mid_rd31_data", d, 0);

    // Delete slot 3 together with an insert whose home is 3
    insert(8'h12, 1'b0, 5'd0, lat, slot, err);
    check("del_pre_slot", slot, 3);
    insert(8'h30, 1'b1, 5'd3, lat, slot, err);
`ifdef HASH_RAM_P_DEL_EN
    check("del_slot", slot, 3);
    check("del_count", count, 1);
    read_slot(5'd3, d, v);
    check("del_rd3", d, 32'h30);
`else
    check("nodel_slot", slot, 4);
    check("nodel_count", count, 2);
    read_slot(5'd3, d, v);
    check("nodel_rd3", d, 32'h12);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
